// File: rtl/adder_arbiter.sv
// Three-way round-robin arbiter sharing one adder: grant, execute, then hold
// the registered result until the consumer acknowledges it.
`ifndef DATASIZE
`define DATASIZE 16
`endif

module adder_arbiter #(
  parameter int datawidth = `DATASIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [3*datawidth-1:0]   opa,
  input  logic [3*datawidth-1:0]   opb,
  output logic [2:0]               gnt,
  output logic [datawidth-1:0]     sum,
  output logic                     cout,
  output logic                     res_valid,
  output logic [1:0]               res_id,
  input  logic                     res_ack,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             last, last_n;
  logic [datawidth-1:0]   a_q, b_q, a_n, b_n;
  logic [2:0]             gnt_n;
  logic [datawidth-1:0]   sum_n;
  logic                   cout_n;
  logic                   rv_n;
  logic [1:0]             id_n;

  logic [1:0]             win;
  logic                   found;
  logic [1:0]             cand;
  logic [datawidth-1:0]   opa_sel, opb_sel;
  logic [datawidth-1:0]   add_sum;
  logic                   add_cout;
  logic                   grant_en;

  adder #(.datawidth(datawidth)) u_adder (
    .a    (a_q),
    .b    (b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Scan starts one past the last winner and wraps, giving round-robin order.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_comb begin
    case (win)
      2'd0:    begin opa_sel = opa[0 +: datawidth];           opb_sel = opb[0 +: datawidth];           end
      2'd1:    begin opa_sel = opa[datawidth +: datawidth];   opb_sel = opb[datawidth +: datawidth];   end
      default: begin opa_sel = opa[2*datawidth +: datawidth]; opb_sel = opb[2*datawidth +: datawidth]; end
    endcase
  end

  always_comb begin
    state_n  = state;
    gnt_n    = '0;
    sum_n    = sum;
    cout_n   = cout;
    rv_n     = res_valid;
    id_n     = res_id;
    last_n   = last;
    a_n      = a_q;
    b_n      = b_q;
    grant_en = 1'b0;
    case (state)
      IDLE: grant_en = |req;
      EXEC: begin
        sum_n   = add_sum;
        cout_n  = add_cout;
        rv_n    = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (res_ack) begin
          rv_n = 1'b0;
          if (|req) grant_en = 1'b1;
          else      state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Shared by IDLE and the back-to-back HOLD acknowledge edge.
    if (grant_en) begin
      gnt_n   = 3'b001 << win;
      a_n     = opa_sel;
      b_n     = opb_sel;
      id_n    = win;
      last_n  = win;
      state_n = EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      last      <= 2'd2;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      sum       <= sum_n;
      cout      <= cout_n;
      res_valid <= rv_n;
      res_id    <= id_n;
      last      <= last_n;
      a_q       <= a_n;
      b_q       <= b_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// Combinational adder producing sum and carry-out at datawidth+1 bits.
module adder #(
  parameter int datawidth = `DATASIZE
) (
  input  logic [datawidth-1:0] a,
  input  logic [datawidth-1:0] b,
  output logic [datawidth-1:0] sum,
  output logic                 cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter at datawidth=16 with hand-computed results.
module tb_adder_arbiter;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req = '0;
  logic [3*DW-1:0] opa = '0;
  logic [3*DW-1:0] opb = '0;
  logic [2:0]      gnt;
  logic [DW-1:0]   sum;
  logic            cout;
  logic            res_valid;
  logic [1:0]      res_id;
  logic            res_ack = 1'b0;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  adder_arbiter #(.datawidth(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .opa       (opa),
    .opb       (opb),
    .gnt       (gnt),
    .sum       (sum),
    .cout      (cout),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_ack   (res_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control view is {gnt, res_valid, res_id, busy}; data view is {cout, sum}.
  task automatic test_reset();
    #3;
    n_cmp++;
    if ({gnt, res_valid, res_id, busy, cout, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b rv=%b id=%0d busy=%b cout=%b sum=%h, want all zero",
               gnt, res_valid, res_id, busy, cout, sum);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({gnt, res_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b rv=%b busy=%b, want 0", gnt, res_valid, busy);
    end
  endtask

  task automatic test_single();
    opa[0 +: DW] = 16'h0005;
    opb[0 +: DW] = 16'h0003;
    req = 3'b001;
    tick();
    n_cmp++;
    if ({gnt, res_valid, busy} !== {3'b001, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b rv=%b busy=%b, want 001/0/1", gnt, res_valid, busy);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if ({gnt, res_valid, res_id, cout, sum} !== {3'b000, 1'b1, 2'd0, 1'b0, 16'h0008}) begin
      n_fail++;
      $display("FAIL single_result: got gnt=%b rv=%b id=%0d cout=%b sum=%h, want 000/1/0/0/0008",
               gnt, res_valid, res_id, cout, sum);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({res_valid, sum, gnt} !== {1'b1, 16'h0008, 3'b000}) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got rv=%b sum=%h gnt=%b, want 1/0008/000", i, res_valid, sum, gnt);
      end
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    n_cmp++;
    if ({res_valid, busy, gnt} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_release: got rv=%b busy=%b gnt=%b, want 0/0/000", res_valid, busy, gnt);
    end
  endtask

  task automatic test_overflow();
    opa[2*DW +: DW] = 16'hFFFF;
    opb[2*DW +: DW] = 16'h0002;
    req = 3'b100;
    tick();
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL overflow_grant: got gnt=%b, want 100", gnt);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if ({res_valid, res_id, cout, sum} !== {1'b1, 2'd2, 1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL overflow_result: got rv=%b id=%0d cout=%b sum=%h, want 1/2/1/0001",
               res_valid, res_id, cout, sum);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_gnt [8];
    logic        exp_rv  [8];
    logic [1:0]  exp_id  [8];
    logic [15:0] exp_sum [8];
    exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    exp_rv  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_id  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    exp_sum = '{16'h0001, 16'h0002, 16'h0002, 16'h001E, 16'h001E, 16'h012C, 16'h012C, 16'h0002};
    opa[0 +: DW]    = 16'd1;   opb[0 +: DW]    = 16'd1;
    opa[DW +: DW]   = 16'd10;  opb[DW +: DW]   = 16'd20;
    opa[2*DW +: DW] = 16'd100; opb[2*DW +: DW] = 16'd200;
    req = 3'b111;
    res_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (gnt !== exp_gnt[i] || res_valid !== exp_rv[i] || res_id !== exp_id[i] ||
          (exp_rv[i] && sum !== exp_sum[i])) begin
        n_fail++;
        $display("FAIL rr_step[%0d]: got gnt=%b rv=%b id=%0d sum=%h, want gnt=%b rv=%b id=%0d sum=%h",
                 i, gnt, res_valid, res_id, sum, exp_gnt[i], exp_rv[i], exp_id[i], exp_sum[i]);
      end
    end
    req = 3'b000;
    tick();
    res_ack = 1'b0;
    n_cmp++;
    if ({res_valid, busy, gnt} !== 5'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got rv=%b busy=%b gnt=%b, want 0/0/000", res_valid, busy, gnt);
    end
  endtask

  task automatic test_stall();
    opa[0 +: DW] = 16'd7;
    opb[0 +: DW] = 16'd9;
    req = 3'b001;
    tick();
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_grant: got gnt=%b, want 001", gnt);
    end
    req = 3'b010;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({gnt, res_valid, res_id, sum} !== {3'b000, 1'b1, 2'd0, 16'h0010}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got gnt=%b rv=%b id=%0d sum=%h, want 000/1/0/0010",
                 i, gnt, res_valid, res_id, sum);
      end
      tick();
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    req = 3'b000;
    n_cmp++;
    if ({gnt, res_valid} !== {3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_b2b: got gnt=%b rv=%b, want 010/0", gnt, res_valid);
    end
    tick();
    n_cmp++;
    if ({res_valid, res_id, sum} !== {1'b1, 2'd1, 16'h001E}) begin
      n_fail++;
      $display("FAIL stall_second: got rv=%b id=%0d sum=%h, want 1/1/001e", res_valid, res_id, sum);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    opa[0 +: DW] = 16'h0100;
    opb[0 +: DW] = 16'h0020;
    req = 3'b001;
    tick();
    req = 3'b000;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, res_valid, res_id, busy, cout, sum} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got gnt=%b rv=%b id=%0d busy=%b cout=%b sum=%h, want all zero",
               gnt, res_valid, res_id, busy, cout, sum);
    end
    tick();
    req = 3'b101;
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({gnt, res_valid} !== {3'b001, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_first_grant: got gnt=%b rv=%b, want 001/0", gnt, res_valid);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if ({res_valid, res_id, sum} !== {1'b1, 2'd0, 16'h0120}) begin
      n_fail++;
      $display("FAIL rst_after_result: got rv=%b id=%0d sum=%h, want 1/0/0120", res_valid, res_id, sum);
    end
    res_ack = 1'b1;
    tick();
  endtask

  task automatic test_ignore();
    res_ack = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({gnt, res_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL ack_in_idle: got gnt=%b rv=%b busy=%b, want 0", gnt, res_valid, busy);
    end
    res_ack = 1'b0;
    opa[DW +: DW] = 16'h1111;
    opb[DW +: DW] = 16'h2222;
    req = 3'b010;
    tick();
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL ign_grant: got gnt=%b, want 010", gnt);
    end
    opa[DW +: DW] = 16'h0000;
    req = 3'b101;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    n_cmp++;
    if ({gnt, res_valid, res_id, sum} !== {3'b000, 1'b1, 2'd1, 16'h3333}) begin
      n_fail++;
      $display("FAIL ign_exec: got gnt=%b rv=%b id=%0d sum=%h, want 000/1/1/3333",
               gnt, res_valid, res_id, sum);
    end
    tick();
    n_cmp++;
    if ({gnt, res_valid, sum} !== {3'b000, 1'b1, 16'h3333}) begin
      n_fail++;
      $display("FAIL ign_hold: got gnt=%b rv=%b sum=%h, want 000/1/3333", gnt, res_valid, sum);
    end
    req = 3'b000;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ign_release: got rv=%b busy=%b, want 0/0", res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_stall();
    test_reset_mid_exec();
    test_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter: datawidth, default `datasize`, operand and result width.
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  3  request per requester (bit0 fetch PC-increment, bit1 branch-target, bit2 ALU).
REQ-005 SHALL have port: opa  input  3*datawidth  packed operand A, slice i = [i*datawidth +: datawidth] belongs to requester i.
REQ-006 SHALL have port: opb  input  3*datawidth  packed operand B, same slicing as opa.
REQ-007 SHALL have port: gnt  output  3  registered one-hot grant, high exactly one cycle per accepted request.
REQ-008 SHALL have port: sum  output  datawidth  registered result.
REQ-009 SHALL have port: cout  output  1  registered carry-out of the addition.
REQ-010 SHALL have port: res_valid  output  1  sum/cout/res_id valid.
REQ-011 SHALL have port: res_id  output  2  index (0..2) of the requester owning the result.
REQ-012 SHALL have port: res_ack  input  1  consumer accepts the result.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-015 SHALL, in IDLE with req!=0, at the edge: pick a winner, set gnt to its one-hot, capture its opa/opb slices into internal operand registers, capture res_id, update last-grant pointer, go to EXEC.
REQ-016 SHALL, in IDLE with req==0, stay in IDLE with gnt=0.
REQ-017 SHALL arbitrate round-robin: priority order starts at (last+1) mod 3 and wraps; last resets to 2 (requester 0 highest after reset).
REQ-018 SHALL, in EXEC, at the edge: register {cout,sum} = captured A + captured B computed at datawidth+1 bits (sum modulo 2^datawidth), set res_valid=1, clear gnt, go to HOLD.
REQ-019 SHALL hold sum, cout, res_id and res_valid=1 stable throughout HOLD until res_ack is sampled high.
REQ-020 SHALL, in HOLD with res_ack=1 and req==0, clear res_valid and go to IDLE.
REQ-021 SHALL, in HOLD with res_ack=1 and req!=0, clear res_valid and perform the REQ-015 grant on the same edge (back-to-back, state to EXEC).
REQ-022 SHALL ignore req in EXEC, and in HOLD without res_ack; a requester that deasserts req before being granted is simply not served.
REQ-023 SHALL ignore res_ack outside HOLD.
REQ-024 SHALL give latency: req high before edge E0 -> gnt high during the cycle after E0 -> res_valid high after E1 (result 2 edges after sampled request).
REQ-025 SHALL perform the addition with one instance of the codebase adder module (datawidth parameter passed through) plus a registered carry bit; no other adders.
REQ-026 SHALL never assert more than one gnt bit, and never assert gnt while res_valid=1 except on the back-to-back edge of REQ-021.

Reset
REQ-027 SHALL, on rst=1 asynchronously regardless of clock: state=IDLE, gnt=0, sum=0, cout=0, res_valid=0, res_id=0, busy=0, last=2, operand registers=0.
REQ-028 SHALL abandon any in-flight operation on reset mid-EXEC or mid-HOLD; no result is produced for it after reset release.
REQ-029 SHALL sample req on the first rising edge after rst deasserts.

Verification (datawidth=16)
REQ-030 SHALL cover single request: req=001, opa0=0x0005, opb0=0x0003 -> gnt=001 one cycle, then sum=0x0008, cout=0, res_id=0, res_valid held until res_ack.
REQ-031 SHALL cover overflow: requester 2, 0xFFFF + 0x0002 -> sum=0x0001, cout=1, res_id=2.
REQ-032 SHALL cover round-robin: req=111 held, res_ack always 1 -> grant order 0,1,2,0 back-to-back, one grant every 2 cycles.
REQ-033 SHALL cover stall: res_ack=0 for 5 cycles with req=010 pending -> no gnt, sum/res_id stable; on res_ack=1 gnt=010 same edge res_valid drops.
REQ-034 SHALL cover reset mid-EXEC: rst pulsed between grant and result -> all outputs 0 immediately, no res_valid after release, next req=100 granted first to requester 2 only if req0 low (req=101 -> requester 0 first).
REQ-035 SHALL cover res_ack in IDLE and req change during EXEC -> no effect on state or outputs.
